// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler driving the select pins of a shared 4:1 mux.
// Each owner is capped at MAX_HOLD consecutive cycles.
// Grant, select, valid and owner-change outputs all come straight from flops.
module mux4_rr_sched #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       sel1,
    output logic       sel0,
    output logic       valid,
    output logic       owner_changed
);

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [NUM_SRC-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic               valid_q, valid_d;
    logic               chg_q, chg_d;

    logic               release_c;
    logic [IDX_W-1:0]   base_c;
    logic [IDX_W-1:0]   idx_c;
    logic               found_c;
    logic [IDX_W-1:0]   win_c;

    // Release the current owner when it drops its request or hits the hold cap
    assign release_c = (state_q == ST_GRANT) &&
                       (!req[sel_q] || (hold_cnt_q == HOLD_LAST));

    // A release searches from the slot after the owner, the same edge ptr moves there
    assign base_c = (state_q == ST_GRANT) ? (sel_q + IDX_W'(1)) : ptr_q;

    // Circular priority search starting at base_c
    always_comb begin
        found_c = 1'b0;
        win_c   = base_c;
        idx_c   = base_c;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            idx_c = base_c + IDX_W'(k);
            if (!found_c && req[idx_c]) begin
                found_c = 1'b1;
                win_c   = idx_c;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            grant_q    <= '0;
            sel_q      <= '0;
            valid_q    <= 1'b0;
            chg_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            grant_q    <= grant_d;
            sel_q      <= sel_d;
            valid_q    <= valid_d;
            chg_q      <= chg_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        grant_d    = grant_q;
        sel_d      = sel_q;
        valid_d    = valid_q;
        chg_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (found_c) begin
                    state_d    = ST_GRANT;
                    grant_d    = NUM_SRC'(1) << win_c;
                    sel_d      = win_c;
                    valid_d    = 1'b1;
                    chg_d      = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                if (release_c) begin
                    ptr_d      = sel_q + IDX_W'(1);
                    hold_cnt_d = '0;
                    if (found_c) begin
                        grant_d = NUM_SRC'(1) << win_c;
                        sel_d   = win_c;
                        valid_d = 1'b1;
                        chg_d   = (win_c != sel_q);
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                        valid_d = 1'b0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign grant         = grant_q;
    assign sel1          = sel_q[1];
    assign sel0          = sel_q[0];
    assign valid         = valid_q;
    assign owner_changed = chg_q;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Directed bench for mux4_rr_sched: one instance at MAX_HOLD=4, one at MAX_HOLD=1.
module tb_mux4_rr_sched;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_a, req_b;
    logic [3:0] grant_a, grant_b;
    logic       sel1_a, sel0_a, valid_a, chg_a;
    logic       sel1_b, sel0_b, valid_b, chg_b;

    int total = 0;
    int bad   = 0;

    mux4_rr_sched #(.MAX_HOLD(4)) u_dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req_a),
        .grant         (grant_a),
        .sel1          (sel1_a),
        .sel0          (sel0_a),
        .valid         (valid_a),
        .owner_changed (chg_a)
    );

    mux4_rr_sched #(.MAX_HOLD(1)) u_dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req_b),
        .grant         (grant_b),
        .sel1          (sel1_b),
        .sel0          (sel0_b),
        .valid         (valid_b),
        .owner_changed (chg_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vectors packed as {grant, sel1, sel0, valid, owner_changed}
    function automatic logic [7:0] obs_a();
        return {grant_a, sel1_a, sel0_a, valid_a, chg_a};
    endfunction

    function automatic logic [7:0] obs_b();
        return {grant_b, sel1_b, sel0_b, valid_b, chg_b};
    endfunction

    function automatic logic [7:0] exp_v(logic [3:0] g, logic [1:0] s, logic v, logic oc);
        return {g, s, v, oc};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed{g,s,v,oc}=%b_%b_%b_%b expected=%b_%b_%b_%b", tag,
                   got[7:4], got[3:2], got[1], got[0], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    // Sample 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] eg;
        logic [1:0] es;
        int         o;

        rst_n = 1'b0;
        req_a = 4'b0000;
        req_b = 4'b0000;
        #1;
        chk("reset_a", obs_a(), exp_v(4'b0000, 2'b00, 1'b0, 1'b0));
        chk("reset_b", obs_b(), exp_v(4'b0000, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request from IDLE, then drop: sel holds at 10
        req_a = 4'b0100;
        step();
        chk("single_grant", obs_a(), exp_v(4'b0100, 2'b10, 1'b1, 1'b1));
        req_a = 4'b0000;
        step();
        chk("single_drop", obs_a(), exp_v(4'b0000, 2'b10, 1'b0, 1'b0));
        step();
        chk("idle_stays", obs_a(), exp_v(4'b0000, 2'b10, 1'b0, 1'b0));

        // ptr is now 3; source 1 wins as the only requester
        req_a = 4'b0010;
        step();
        chk("early_own1", obs_a(), exp_v(4'b0010, 2'b01, 1'b1, 1'b1));
        step();
        chk("early_hold", obs_a(), exp_v(4'b0010, 2'b01, 1'b1, 1'b0));
        // Owner drops; search starts at 2 so 3 beats 0
        req_a = 4'b1001;
        step();
        chk("early_rel", obs_a(), exp_v(4'b1000, 2'b11, 1'b1, 1'b1));
        // Non-owner request changes do not disturb owner 3
        req_a = 4'b1110;
        step();
        chk("nonowner_chg", obs_a(), exp_v(4'b1000, 2'b11, 1'b1, 1'b0));
        req_a = 4'b0000;
        step();
        chk("early_idle", obs_a(), exp_v(4'b0000, 2'b11, 1'b0, 1'b0));

        // Lone requester at the hold limit: re-granted with no gap and no new pulse
        req_a = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("lone_c%0d", c), obs_a(), exp_v(4'b0001, 2'b00, 1'b1, c == 0));
        end
        req_a = 4'b1111;
        step();
        // ptr moved to 1 at the last limit re-grant; owner 0 keeps requesting,
        // hold was 1, so owner 0 keeps the grant
        chk("lone_then_all", obs_a(), exp_v(4'b0001, 2'b00, 1'b1, 1'b0));

        // Asynchronous reset mid-grant drops everything immediately
        rst_n = 1'b0;
        #1;
        chk("rst_mid_a", obs_a(), exp_v(4'b0000, 2'b00, 1'b0, 1'b0));
        @(negedge clk);
        rst_n = 1'b1;

        // Fair rotation with everyone requesting: 4 cycles each starting at source 0
        for (int c = 0; c < 17; c++) begin
            step();
            o  = (c / 4) % 4;
            eg = 4'b0001 << o;
            es = 2'(o);
            chk($sformatf("rot_c%0d", c), obs_a(), exp_v(eg, es, 1'b1, (c % 4) == 0));
        end
        req_a = 4'b0000;
        step();
        chk("rot_idle", obs_a(), exp_v(4'b0000, 2'b00, 1'b0, 1'b0));

        // MAX_HOLD=1: strict per-cycle alternation between sources 0 and 2
        req_b = 4'b0101;
        for (int c = 0; c < 6; c++) begin
            step();
            eg = (c % 2 == 0) ? 4'b0001 : 4'b0100;
            es = (c % 2 == 0) ? 2'b00 : 2'b10;
            chk($sformatf("mh1_c%0d", c), obs_b(), exp_v(eg, es, 1'b1, 1'b1));
        end
        req_b = 4'b0000;
        step();
        chk("mh1_idle", obs_b(), exp_v(4'b0000, 2'b10, 1'b0, 1'b0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
